// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO result registers.
// One shift-add or restoring-subtract step per cycle; fixed latency of WIDTH+1 cycles from accept.
//
// Ports:
//   clock_i        rising-edge clock
//   reset_ni       asynchronous active-low reset
//   start_i        request a new operation (sampled only while idle)
//   op_i           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   op1_i / op2_i  multiplicand/dividend, multiplier/divisor
//   busy_o         operation in flight
//   done_o         one-cycle pulse when HI/LO update
//   hi_o / lo_o    product halves, or remainder/quotient
//   div_by_zero_o  last completed divide had a zero divisor
module mips_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   a_q, a_d;          // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;      // {partial/remainder, multiplier/quotient}
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_mag, op2_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  // Operand magnitudes; the most-negative value maps onto itself, which is its correct
  // unsigned magnitude.
  always_comb begin
    op1_neg = op_i[0] & op1_i[WIDTH-1];
    op2_neg = op_i[0] & op2_i[WIDTH-1];
    op1_mag = op1_neg ? -op1_i : op1_i;
    op2_mag = op2_neg ? -op2_i : op2_i;
  end

  // Datapath steps and final sign correction.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, a_q};
    if (!rem_diff[WIDTH]) begin
      div_next = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    prod = neg_res_q ? -acc_q : acc_q;
    quot = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    a_d        = a_q;
    acc_d      = acc_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dbz_pend_d = dbz_pend_q;
    dividend_d = dividend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StCalc;
          cnt_d      = CntW'(WIDTH);
          is_div_d   = op_i[1];
          a_d        = op2_mag;
          acc_d      = {{WIDTH{1'b0}}, op1_mag};
          neg_res_d  = op1_neg ^ op2_neg;
          neg_rem_d  = op1_neg;
          dbz_pend_d = op_i[1] & (op2_i == '0);
          dividend_d = op1_i;
          dbz_d      = 1'b0;
        end
      end
      StCalc: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (dbz_pend_q) begin
          hi_d  = dividend_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      a_q        <= '0;
      acc_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      dividend_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      a_q        <= a_d;
      acc_q      <= acc_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dbz_pend_q <= dbz_pend_d;
      dividend_q <= dividend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit at WIDTH=32: table of operations with hand-computed
// HI/LO results, plus sequences for ignored start, async reset and back-to-back issue.
module tb_mips_muldiv_unit;

  localparam int unsigned W = 32;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] op1, op2;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clock_i      (clock),
    .reset_ni     (reset_n),
    .start_i      (start),
    .op_i         (op),
    .op1_i        (op1),
    .op2_i        (op2),
    .busy_o       (busy),
    .done_o       (done),
    .hi_o         (hi),
    .lo_o         (lo),
    .div_by_zero_o(dbz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    bit           b2b;
  } vec_t;

  localparam logic [1:0] OpMultu = 2'b00;
  localparam logic [1:0] OpMult  = 2'b01;
  localparam logic [1:0] OpDivu  = 2'b10;
  localparam logic [1:0] OpDiv   = 2'b11;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation and wait for done. When b2b is set, start is raised immediately
  // (caller is in the done cycle); otherwise it is raised at the next falling edge.
  // A nonzero poke_at raises start with junk operands for one cycle mid-operation.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit b2b, input int poke_at, output int lat, output int busy_cnt);
    logic [W-1:0] hi_prev, lo_prev;
    if (!b2b) @(negedge clock);
    hi_prev = hi;
    lo_prev = lo;
    start = 1'b1;
    op    = o;
    op1   = a;
    op2   = b;
    @(posedge clock);
    #1;
    start    = 1'b0;
    op1      = '0;
    op2      = '0;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    check("dbz_clear_on_accept", {63'd0, dbz}, 64'd0);
    while (!done && lat < 100) begin
      if (lat == poke_at && poke_at != 0) begin
        start = 1'b1;
        op    = OpMultu;
        op1   = 32'd1;
        op2   = 32'd1;
      end else begin
        start = 1'b0;
      end
      if (lat == 16) check("hold_hilo", {hi, lo}, {hi_prev, lo_prev});
      @(posedge clock);
      #1;
      lat++;
      if (busy) busy_cnt++;
      if (busy && done) check("busy_done_overlap", 64'd1, 64'd0);
    end
    start = 1'b0;
    if (lat >= 100) check("done_timeout", 64'(lat), 64'(W + 1));
  endtask

  int lat, bcnt;

  initial begin
    vecs[0]  = '{OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0};
    vecs[1]  = '{OpMult,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0};
    vecs[2]  = '{OpDiv,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
    vecs[3]  = '{OpDivu,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 1'b1};
    vecs[4]  = '{OpDiv,   32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[5]  = '{OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
    vecs[6]  = '{OpMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
    vecs[7]  = '{OpDivu,  32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[8]  = '{OpDiv,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b1};
    vecs[9]  = '{OpMultu, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[10] = '{OpDivu,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b0};
    vecs[11] = '{OpMult,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0};

    reset_n = 1'b0;
    start   = 1'b0;
    op      = '0;
    op1     = '0;
    op2     = '0;
    #23;
    check("reset_outputs", {57'd0, busy, done, dbz, 4'd0}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].b2b, 0, lat, bcnt);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(W + 1));
      check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(W + 1));
      check($sformatf("v%0d_hilo", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
      check($sformatf("v%0d_dbz", i), {63'd0, dbz}, {63'd0, vecs[i].dbz});
      check($sformatf("v%0d_busy_low", i), {63'd0, busy}, 64'd0);
    end

    // done lasts exactly one cycle
    @(posedge clock);
    #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);

    // start pulsed at cycle 10 of a MULTU is ignored
    run_op(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 10, lat, bcnt);
    check("poke_latency", 64'(lat), 64'(W + 1));
    check("poke_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    repeat (3) begin
      @(posedge clock);
      #1;
      if (busy || done) check("poke_no_restart", {62'd0, busy, done}, 64'd0);
    end
    check("poke_idle", {62'd0, busy, done}, 64'd0);

    // asynchronous reset in the middle of CALC
    @(negedge clock);
    start = 1'b1;
    op    = OpDivu;
    op1   = 32'd100;
    op2   = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_ctrl", {61'd0, busy, done, dbz}, 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op(OpMultu, 32'd6, 32'd7, 1'b0, 0, lat, bcnt);
    check("post_reset_latency", 64'(lat), 64'(W + 1));
    check("post_reset_hilo", {hi, lo}, 64'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout required completion");
    $fatal(1);
  end

endmodule
